// File: rtl/magnitude_comparator_pkg.sv
// rtl/magnitude_comparator_pkg.sv - shared state type and step-count helper for the magnitude comparator sequencer
//
// Contents:
//   state_t   : sequencer state (IDLE, RUN, DONE)
//   steps_of  : number of CHUNK-wide compare steps needed to cover WIDTH bits
package magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/magnitude_comparator_chunk.sv
// rtl/magnitude_comparator_chunk.sv - combinational CHUNK-bit unsigned magnitude compare
//
// Ports:
//   a, b : CHUNK-bit unsigned operands
//   gt   : a > b
//   lt   : a < b   (both low means a == b)
module magnitude_comparator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/magnitude_comparator_sequencer.sv
// rtl/magnitude_comparator_sequencer.sv - multi-cycle magnitude comparator, MSB chunk first, valid/ready in and out
//
// Build option: MAGNITUDE_COMPARATOR_SEQUENCER_EARLY_EXIT_EN
//   defined   : RUN ends on the first differing chunk (data-dependent latency)
//   undefined : RUN always lasts WIDTH/CHUNK cycles (constant latency)
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_vld, o_rdy : operand handshake (accepted when both high, only in IDLE)
//   i_a, i_b     : WIDTH-bit unsigned operands
//   o_vld, i_rdy : result handshake (consumed when both high, only in DONE)
//   o_a          : a > b
//   o_b          : b > a (both low means a == b)
//   o_bsy        : high in RUN or DONE
module magnitude_comparator_sequencer
    import magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic             o_a,
    output logic             o_b,
    output logic             o_bsy
);

    localparam int STEPS = steps_of(WIDTH, CHUNK);
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

`ifdef MAGNITUDE_COMPARATOR_SEQUENCER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("magnitude_comparator_sequencer: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic              chunk_gt;
    logic              chunk_lt;

    // The single shared comparator always looks at the top chunk; the
    // shift registers bring the next-lower chunk up each RUN cycle.
    magnitude_comparator_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (sh_a_q[WIDTH-1 -: CHUNK]),
        .b  (sh_b_q[WIDTH-1 -: CHUNK]),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (i_vld) begin
                    sh_a_d  = i_a;
                    sh_b_d  = i_b;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    cnt_d   = CW'(STEPS - 1);
                    state_d = RUN;
                end
            end

            RUN: begin
                // First differing chunk decides; once a flag is set the
                // remaining lower chunks cannot change the verdict.
                if (!gt_q && !lt_q) begin
                    gt_d = chunk_gt;
                    lt_d = chunk_lt;
                end
                sh_a_d = sh_a_q << CHUNK;
                sh_b_d = sh_b_q << CHUNK;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if ((cnt_q == '0) || (EARLY_EXIT && (chunk_gt || chunk_lt))) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs depend on registered state only.
    assign o_rdy = (state_q == IDLE);
    assign o_vld = (state_q == DONE);
    assign o_bsy = (state_q != IDLE);
    assign o_a   = gt_q;
    assign o_b   = lt_q;

endmodule
